// File: rtl/demux1_3_buf_pkg.sv
// rtl/demux1_3_buf_pkg.sv - shared select encodings and destination indices for the result router
package demux1_3_buf_pkg;

   localparam int WIDTH_DEF = 19;

   localparam logic [1:0] SEL_A   = 2'b00;
   localparam logic [1:0] SEL_B   = 2'b01;
   localparam logic [1:0] SEL_C   = 2'b11;
   localparam logic [1:0] SEL_BAD = 2'b10;

   typedef logic [1:0] dest_t;

   localparam dest_t DST_A = 2'd0;
   localparam dest_t DST_B = 2'd1;
   localparam dest_t DST_C = 2'd2;

   // Mirrors the 3:1 source-select encoding; the unused code falls back to port a.
   function automatic dest_t decode_sel(input logic [1:0] sel);
      dest_t d;
      case (sel)
         SEL_A:   d = DST_A;
         SEL_B:   d = DST_B;
         SEL_C:   d = DST_C;
         default: d = DST_A;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/demux1_3_buf_sync_fifo.sv
// rtl/demux1_3_buf_sync_fifo.sv - single-clock FIFO with push/pop, occupancy count and empty flag
module sync_fifo #(
   parameter int W     = 21,
   parameter int DEPTH = 2,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [CW-1:0] count,
   output logic          empty
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];

   // DEPTH is a power of two, so pointer wrap is the natural PW-bit rollover.
   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !rst) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/demux1_3_buf.sv
// rtl/demux1_3_buf.sv - buffered 1-to-3 result router with per-port valid/ready and illegal-select flag
module demux1_3_buf
   import demux1_3_buf_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   output logic             a_valid,
   output logic             b_valid,
   output logic             c_valid,
   input  logic             a_ready,
   input  logic             b_ready,
   input  logic             c_ready,
   output logic [WIDTH-1:0] a_data,
   output logic [WIDTH-1:0] b_data,
   output logic [WIDTH-1:0] c_data,
   output logic             sel_err
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH+1:0] head;
   logic [WIDTH-1:0] head_data;
   dest_t            head_dest;
   logic [CW-1:0]    count;
   logic             empty;
   logic             push;
   logic             pop;
   logic             head_valid;
   logic             sel_err_q, sel_err_d;

   // in_ready looks only at registered occupancy, so a pop never frees a slot in the same cycle.
   assign in_ready = !rst && (count != CW'(DEPTH));
   assign push     = in_valid && in_ready;

   sync_fifo #(
      .W     (WIDTH + 2),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({in_data, decode_sel(in_sel)}),
      .rdata (head),
      .count (count),
      .empty (empty)
   );

   assign head_data  = head[WIDTH+1:2];
   assign head_dest  = head[1:0];
   assign head_valid = !rst && !empty;

   assign a_valid = head_valid && (head_dest == DST_A);
   assign b_valid = head_valid && (head_dest == DST_B);
   assign c_valid = head_valid && (head_dest == DST_C);

   assign a_data = a_valid ? head_data : '0;
   assign b_data = b_valid ? head_data : '0;
   assign c_data = c_valid ? head_data : '0;

   assign pop = (a_valid && a_ready) || (b_valid && b_ready) || (c_valid && c_ready);

   assign sel_err_d = push && (in_sel == SEL_BAD);
   assign sel_err   = sel_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_err_q <= 1'b0;
      end else begin
         sel_err_q <= sel_err_d;
      end
   end

endmodule

// File: doc/demux1_3_buf.md
Name: demux1_3_buf

Overview:
- Registered 1-to-3 result router for the 19-bit CPU datapath.
- Accepts one 19-bit word plus a 2-bit destination select over a valid/ready handshake, buffers it in a small FIFO, and presents it on exactly one of three destination ports (a, b, c), each with its own valid/ready.
- Mirrors the 3:1 source-select encoding so the same select fields drive both directions.

Parameters:
- WIDTH, 19, data word width.
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  word to route.
- in_sel  input  2  destination select: 00=a, 01=b, 11=c, 10=illegal (routes to a).
- a_valid / b_valid / c_valid  output  1  head word is destined for this port.
- a_ready / b_ready / c_ready  input  1  consumer accepts.
- a_data / b_data / c_data  output  WIDTH  head word on the selected port, zero on the others.
- sel_err  output  1  one-cycle registered pulse: an illegal select was accepted.

Behaviour:
- Storage: DEPTH entries of {data, dest[1:0]}, where dest is an internal index 0=a, 1=b, 2=c. Also a write pointer, a read pointer, and count (0..DEPTH).
- Select decode at push: 00→0, 01→1, 11→2, 10→0. sel_err is 1 in the cycle after a push with in_sel=10, otherwise 0.
- Push: in_valid && in_ready at a clock edge.
- in_ready = !rst && (count != DEPTH).
  - Depends on registered state only; there is no combinational path from any x_ready to in_ready.
- Head presentation, when count > 0:
  - Exactly one x_valid = 1, chosen by the head entry's dest.
  - That port's x_data = head data; the other two x_data = 0.
- When count = 0: all x_valid = 0 and all x_data = 0.
- Pop: the selected x_valid && x_ready at a clock edge.
  - Ready on non-selected ports is ignored.
  - Consumers may hold ready high.
- Latency: a word pushed at edge N into an empty FIFO is visible on its port in the cycle after edge N (1 cycle). There is no same-cycle in→out bypass.
- Throughput: one word per cycle sustained when the consumer is always ready.
- Simultaneous push and pop (count < DEPTH): count unchanged, both pointers advance.
- Full (count = DEPTH): in_ready = 0. A pop that cycle does not enable a same-cycle push; in_ready rises the next cycle.
- Empty: no pop occurs, even if the x_ready inputs are high.
- Pointer wrap: modulo DEPTH; order is strict FIFO across all destinations.
  - A blocked head word (consumer not ready) stalls words for every other port: head-of-line blocking is intended.
- Holding: x_valid and x_data stay stable until the pop.
- Reset (synchronous, any time including mid-transfer):
  - count, pointers, and sel_err go to 0.
  - All x_valid = 0, all x_data = 0, in_ready = 0 while rst is high.
  - Buffered words are discarded.
  - in_ready = 1 in the first cycle after rst drops.

Decomposition:
- Shared package holds:
  - WIDTH default (19).
  - Select encodings SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b11, SEL_BAD=2'b10.
  - Destination indices DST_A/B/C.
- One sub-module, sync_fifo: synchronous FIFO of width WIDTH+2 and depth DEPTH, with push/pop/count/full/empty.
- The top level holds the select decode, the output steering, and sel_err.

Test Plan:
- Reset then idle: after rst is held high for 2 cycles and released, in_ready=1, all x_valid=0, all x_data=0, sel_err=0.
- Single routes: push 19'h7FFFF sel 11 with c_ready=1 → next cycle c_valid=1, c_data=19'h7FFFF, a/b valid=0 and data=0; popped on that edge, FIFO empty the following cycle.
- Order and backpressure: push 19'h00001/a, 19'h00002/b, 19'h00003/c with all readies=0 → in_ready=0 after the 2nd push. Raise b_ready only → nothing pops (head is a). Raise a_ready → 1 then 2 emerge in order, then 3 on c.
- Streaming: all readies=1 and 16 back-to-back pushes cycling a,b,c → one output per cycle, 1-cycle latency, count never exceeds 1, in_ready constantly 1.
- Illegal select: push 19'h12345 with sel 10 → sel_err pulses for exactly 1 cycle, word appears on a_data.
- Reset mid-operation: FIFO full with a_ready=0, assert rst for 1 cycle → FIFO cleared, no x_valid afterwards, the pre-reset words never appear.
